// File: rtl/next_pc_ctrl.sv
// next_pc_ctrl: fetches the instruction at Count over req/ack, decodes its
// control-flow class and drives PC Target/Halt so the PC advances once per
// instruction. Define NEXT_PC_TIMEOUT_EN to compile in the fetch timeout
// counter, the FAULT state and a live Fault output.
module next_pc_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        Init_n,
    input  logic [15:0] Count,
    input  logic        BrCond,
    input  logic        IMemAck,
    input  logic [15:0] IMemData,
    output logic [15:0] Target,
    output logic        Halt,
    output logic        IMemReq,
    output logic [15:0] IMemAddr,
    output logic [15:0] Instr,
    output logic        InstrValid,
    output logic        Fault
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] REQ    = 3'd1;
    localparam logic [2:0] ISSUE  = 3'd2;
    localparam logic [2:0] HALTED = 3'd3;
`ifdef NEXT_PC_TIMEOUT_EN
    localparam logic [2:0] FAULT  = 3'd4;
    localparam logic [7:0] LAST   = 8'(TIMEOUT - 1);
    logic [7:0] tmo;
`endif
    logic [2:0]  state, state_nxt;
    logic [15:0] target_nxt;
    logic [3:0]  op;
    logic        take_ack;

    assign op         = IMemData[15:12];
    assign take_ack   = (state == REQ) && IMemAck;
    assign IMemAddr   = Count;
    assign Halt       = state != ISSUE;
    assign InstrValid = state == ISSUE;
    assign target_nxt = (op == 4'hC)           ? {Count[15:12], IMemData[11:0]} :
                        (op == 4'hD && BrCond) ? Count + {{8{IMemData[7]}}, IMemData[7:0]} :
                        (op == 4'hF)           ? Count :
                                                 Count + 16'd1;

    // state sequencing: ack only counts in REQ; HALTED/FAULT hold until reset
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = REQ;
            REQ: begin
                if (IMemAck)
                    state_nxt = (op == 4'hF) ? HALTED : ISSUE;
`ifdef NEXT_PC_TIMEOUT_EN
                else if (tmo == LAST)
                    state_nxt = FAULT;
`endif
            end
            ISSUE: state_nxt = REQ;
            default: state_nxt = state;
        endcase
    end

    // state, request and the instruction/target latched on the ack edge
    always_ff @(posedge CLK) begin
        if (!Init_n) begin
            state   <= IDLE;
            Target  <= 16'h0000;
            IMemReq <= 1'b0;
            Instr   <= 16'h0000;
        end else begin
            state   <= state_nxt;
            IMemReq <= state_nxt == REQ;
            if (take_ack) begin
                Instr  <= IMemData;
                Target <= target_nxt;
            end
        end
    end

`ifdef NEXT_PC_TIMEOUT_EN
    // counts REQ cycles; zero outside REQ so each fetch starts fresh
    always_ff @(posedge CLK) begin
        if (!Init_n || state != REQ)
            tmo <= 8'd0;
        else
            tmo <= tmo + 8'd1;
    end

    assign Fault = state == FAULT;
`else
    assign Fault = 1'b0;
`endif
endmodule

// File: doc/next_pc_ctrl.md
# next_pc_ctrl

Fetch/next-address controller that sits on the output side of the program counter. It takes the current `Count`, fetches the instruction at that address from instruction memory over a req/ack handshake, and decodes the instruction's control-flow class. It then drives the PC's `Target` and `Halt` inputs so that the PC advances exactly once per fetched instruction and freezes on HALT, on a memory fault, or while a fetch is outstanding.

## Interface
- `TIMEOUT`, default 16: max REQ cycles without `IMemAck` before fault (only with `NEXT_PC_TIMEOUT_EN`); legal 2..255.
- `CLK` in 1: single clock; all state updates on rising edge.
- `Init_n` in 1: reset, synchronous, active-low.
- `Count` in 16: current PC value.
- `BrCond` in 1: branch condition from execute; sampled on the ack edge.
- `IMemAck` in 1: instruction memory data valid.
- `IMemData` in 16: instruction word; valid when `IMemAck`=1.
- `Target` out 16: next PC value, registered.
- `Halt` out 1: PC hold request.
- `IMemReq` out 1: fetch request, registered.
- `IMemAddr` out 16: fetch address = `Count`, combinational.
- `Instr` out 16: last fetched instruction, registered.
- `InstrValid` out 1: one-cycle strobe, `Instr` issued to datapath.
- `Fault` out 1: sticky fetch timeout flag.

## Operation
- States: IDLE, REQ, ISSUE, HALTED, FAULT.
- IDLE → REQ unconditionally on the first edge with `Init_n`=1.
- REQ:
  - `IMemReq`=1 and `Halt`=1.
  - `IMemAck` is sampled only in REQ; ack in any other state is ignored.
  - On an ack edge:
    - `Instr` ← `IMemData`.
    - `Target` ← computed next address.
    - Next state is HALTED if opcode `IMemData[15:12]`=4'hF, else ISSUE.
- Decode, from `IMemData`:
  - Opcode 4'hC (JMP): `Target` = {`Count[15:12]`, `IMemData[11:0]`}.
  - Opcode 4'hD (BR): `Target` = `Count` + signext(`IMemData[7:0]`) if `BrCond`=1, else `Count`+1.
  - Opcode 4'hF (HALT): `Target` = `Count`.
  - Any other opcode: `Target` = `Count`+1.
- Arithmetic: all address math is 16-bit modulo 2^16. 0xFFFF+1 = 0x0000. 0x0002 + signext(0xFC) = 0xFFFE.
- ISSUE:
  - `Halt`=0, `InstrValid`=1, `IMemReq`=0 for exactly one cycle.
  - The PC loads `Target` on the closing edge.
  - Next state is REQ.
- HALTED: `Halt`=1, `IMemReq`=0. Held until reset. `InstrValid` is not pulsed for HALT.
- FAULT: `Halt`=1, `Fault`=1, `IMemReq`=0. Held until reset.

## Timing
- Reset values (the edge with `Init_n`=0):
  - `Target`=0, `Halt`=1, `IMemReq`=0, `Instr`=0, `InstrValid`=0, `Fault`=0.
  - State = IDLE; timeout counter = 0.
- Reset mid-REQ: `IMemReq` drops on that same edge. A late ack is ignored because the state is no longer REQ.
- `IMemReq` first rises one cycle after reset release (IDLE occupies one cycle).
- Minimum throughput: 2 cycles per instruction (1 REQ cycle with immediate ack, then 1 ISSUE cycle).
- Each additional wait cycle of the memory adds 1 cycle.
- `Halt` is 0 only during ISSUE, so the PC changes exactly once per non-HALT instruction.
- `IMemAddr` follows `Count` combinationally. `Count` is stable throughout REQ because `Halt`=1.
- `Target` and `Instr` update on the ack edge and remain stable through ISSUE until the next ack edge.
- Timeout counter:
  - Clears on entry to REQ and increments each REQ cycle without ack.
  - When the counter equals `TIMEOUT`-1 and ack is still 0, the next state is FAULT.
  - If ack arrives on that same cycle, the ack wins and no fault is raised.

## Configuration
- `NEXT_PC_TIMEOUT_EN`:
  - Defined: the timeout counter, the FAULT state and a live `Fault` output are compiled in as described above.
  - Undefined: no counter or FAULT state; REQ waits indefinitely for `IMemAck`; `Fault` is tied to 0.

## Test plan
- Reset, then `Count`=0x0010 with ack on the first REQ cycle and `IMemData`=0x1234 → `Target`=0x0011, `Instr`=0x1234, one `InstrValid` pulse, `Halt` low exactly 1 cycle, 2 cycles per instruction.
- `Count`=0x0002, `IMemData`=0xD0FC, `BrCond`=1 → `Target`=0xFFFE. Repeat with `BrCond`=0 → `Target`=0x0003.
- `Count`=0xA123, `IMemData`=0xC456 → `Target`=0xA456. Then `Count`=0xFFFF with a non-control opcode → `Target`=0x0000.
- `IMemData`=0xF000 → `Halt` stays 1 forever, no `InstrValid`, `IMemReq`=0. `Init_n`=0 for one cycle → restart from IDLE with all outputs at reset values.
- With `NEXT_PC_TIMEOUT_EN` and `TIMEOUT`=4, no ack → `Fault`=1 after 4 REQ cycles. Ack on the 4th REQ cycle → ISSUE, `Fault`=0. Without the macro, no ack → stays in REQ, `Fault`=0.
- `Init_n` asserted during REQ with ack on the following cycle → `IMemReq` drops on the reset edge, the ack is ignored, `Instr` remains 0.
